// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the FSM state encoding, the port-id and operation enums, the default
// parameter values and the round-robin pick helper used by the arbiter.
package sram_arbiter_pkg;

   // Default parameter values for the arbiter and its interface
   localparam int DEF_ADDR_W  = 18;
   localparam int DEF_WDATA_W = 32;
   localparam int DEF_RDATA_W = 64;
   localparam int DEF_TIMEOUT = 255;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   // Requesting port identifiers
   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   // Latched operation of the transaction in flight
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // Round-robin choice: a lone requester wins outright; on a tie the port
   // that was not granted last wins.
   function automatic port_e pick_port(input logic req0, input logic req1,
                                       input port_e last);
      port_e win;
      if (req0 && req1) begin
         win = (last == PORT0) ? PORT1 : PORT0;
      end else if (req1) begin
         win = PORT1;
      end else begin
         win = PORT0;
      end
      return win;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of both client ports plus the SRAM-controller side of the arbiter.
// Latency: n/a (wires only).
// Backpressure: clients hold r_en/w_en until their one-cycle ready pulse.
//
// Ports (per client N = 0,1): pN_address, pN_wdata, pN_r_en, pN_w_en in;
// pN_rdata, pN_ready, pN_error, pN_grant out. SRAM side: sram_address,
// sram_wdata, sram_r_en, sram_w_en out; sram_rdata, sram_ready in.
// Modport slave is the arbiter's view; master is the environment's view.
interface sram_arbiter_if
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int WDATA_W = DEF_WDATA_W,
   parameter int RDATA_W = DEF_RDATA_W
);

   // Client port 0
   logic [ADDR_W-1:0]  p0_address;
   logic [WDATA_W-1:0] p0_wdata;
   logic               p0_r_en;
   logic               p0_w_en;
   logic [RDATA_W-1:0] p0_rdata;
   logic               p0_ready;
   logic               p0_error;
   logic               p0_grant;

   // Client port 1
   logic [ADDR_W-1:0]  p1_address;
   logic [WDATA_W-1:0] p1_wdata;
   logic               p1_r_en;
   logic               p1_w_en;
   logic [RDATA_W-1:0] p1_rdata;
   logic               p1_ready;
   logic               p1_error;
   logic               p1_grant;

   // SRAM controller side
   logic [ADDR_W-1:0]  sram_address;
   logic [WDATA_W-1:0] sram_wdata;
   logic               sram_r_en;
   logic               sram_w_en;
   logic [RDATA_W-1:0] sram_rdata;
   logic               sram_ready;

   modport slave (
      input  p0_address, p0_wdata, p0_r_en, p0_w_en,
      output p0_rdata, p0_ready, p0_error, p0_grant,
      input  p1_address, p1_wdata, p1_r_en, p1_w_en,
      output p1_rdata, p1_ready, p1_error, p1_grant,
      output sram_address, sram_wdata, sram_r_en, sram_w_en,
      input  sram_rdata, sram_ready
   );

   modport master (
      output p0_address, p0_wdata, p0_r_en, p0_w_en,
      input  p0_rdata, p0_ready, p0_error, p0_grant,
      output p1_address, p1_wdata, p1_r_en, p1_w_en,
      input  p1_rdata, p1_ready, p1_error, p1_grant,
      input  sram_address, sram_wdata, sram_r_en, sram_w_en,
      output sram_rdata, sram_ready
   );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller.
// Latency: grant 1 cycle after request; ready/rdata 1 cycle after sram_ready.
// Backpressure: losing port waits in place; owner held off by sram_ready/timeout.
//
// Ports: clk, rst (async active-low), bus (sram_arbiter_if.slave) carrying
// both client ports and the SRAM-controller side.
// Flow: IDLE picks a requester and latches its request; BUSY drives the SRAM
// until sram_ready or TIMEOUT cycles elapse; RELEASE is a one-cycle dead slot
// that carries the ready/error pulse before arbitration resumes.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int WDATA_W = DEF_WDATA_W,
   parameter int RDATA_W = DEF_RDATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic           clk,
   input logic           rst,
   sram_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // FSM and transaction state
   state_e             state_q, state_d;
   port_e              port_q, port_d;
   port_e              last_q, last_d;
   op_e                op_q, op_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WDATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Registered per-port completion outputs
   logic               ready0_q, ready0_d;
   logic               ready1_q, ready1_d;
   logic               error0_q, error0_d;
   logic               error1_q, error1_d;
   logic [RDATA_W-1:0] rdata0_q, rdata0_d;
   logic [RDATA_W-1:0] rdata1_q, rdata1_d;

   logic  req0, req1;
   logic  timeout_hit;
   logic  busy;
   port_e win;

   always_comb begin
      req0 = bus.p0_r_en | bus.p0_w_en;
      req1 = bus.p1_r_en | bus.p1_w_en;
      win  = pick_port(req0, req1, last_q);
      // Counter starts at 0 in the first BUSY cycle, so this fires in the
      // TIMEOUT-th BUSY cycle.
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.sram_ready || timeout_hit) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Transaction datapath: latch on grant, count in BUSY, complete/abort
   // ---------------------------------------------------------------------
   always_comb begin
      port_d   = port_q;
      last_d   = last_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ready0_d = 1'b0;
      ready1_d = 1'b0;
      error0_d = 1'b0;
      error1_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               port_d = win;
               last_d = win;
               cnt_d  = '0;
               if (win == PORT0) begin
                  // Write wins when a port raises both enables
                  op_d    = bus.p0_w_en ? OP_WRITE : OP_READ;
                  addr_d  = bus.p0_address;
                  wdata_d = bus.p0_wdata;
               end else begin
                  op_d    = bus.p1_w_en ? OP_WRITE : OP_READ;
                  addr_d  = bus.p1_address;
                  wdata_d = bus.p1_wdata;
               end
            end
         end
         ST_BUSY: begin
            // A completion in the last allowed cycle beats the abort.
            if (bus.sram_ready) begin
               if (port_q == PORT0) begin
                  ready0_d = 1'b1;
                  if (op_q == OP_READ) begin
                     rdata0_d = bus.sram_rdata;
                  end
               end else begin
                  ready1_d = 1'b1;
                  if (op_q == OP_READ) begin
                     rdata1_d = bus.sram_rdata;
                  end
               end
            end else if (timeout_hit) begin
               // Abort: pulse ready with error, leave read data untouched
               if (port_q == PORT0) begin
                  ready0_d = 1'b1;
                  error0_d = 1'b1;
               end else begin
                  ready1_d = 1'b1;
                  error1_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         port_q   <= PORT0;
         last_q   <= PORT1;   // port 0 wins the first tie after reset
         op_q     <= OP_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ready0_q <= 1'b0;
         ready1_q <= 1'b0;
         error0_q <= 1'b0;
         error1_q <= 1'b0;
      end else begin
         port_q   <= port_d;
         last_q   <= last_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ready0_q <= ready0_d;
         ready1_q <= ready1_d;
         error0_q <= error0_d;
         error1_q <= error1_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs. Enables and grants decode straight from the state
   // register so an async reset drops them in the same cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      busy             = (state_q == ST_BUSY);
      bus.sram_address = addr_q;
      bus.sram_wdata   = wdata_q;
      bus.sram_r_en    = busy && (op_q == OP_READ);
      bus.sram_w_en    = busy && (op_q == OP_WRITE);
      bus.p0_grant     = busy && (port_q == PORT0);
      bus.p1_grant     = busy && (port_q == PORT1);
      bus.p0_ready     = ready0_q;
      bus.p1_ready     = ready1_q;
      bus.p0_error     = error0_q;
      bus.p1_error     = error1_q;
      bus.p0_rdata     = rdata0_q;
      bus.p1_rdata     = rdata1_q;
   end

endmodule
